// File: rtl/aes_block_sequencer_if.sv
// Byte-stream and AES-core handshake bundle for aes_block_sequencer.
// master = sequencer side, slave = environment (USB paths and AES core).
interface aes_block_sequencer_if;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         rx_eop;
  logic         rx_ready;
  logic         aes_start;
  logic [127:0] aes_block_in;
  logic         aes_done;
  logic [127:0] aes_block_out;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_eop;
  logic         tx_ready;

  modport master (
    input  rx_valid, rx_data, rx_eop, aes_done, aes_block_out, tx_ready,
    output rx_ready, aes_start, aes_block_in, tx_valid, tx_data, tx_eop
  );
  modport slave (
    output rx_valid, rx_data, rx_eop, aes_done, aes_block_out, tx_ready,
    input  rx_ready, aes_start, aes_block_in, tx_valid, tx_data, tx_eop
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// Gathers 16 rx bytes, runs one AES block with a timeout, streams the result to tx.
// Optional macro AES_SEQ_PAD_FLUSH_EN: early rx_eop zero-pads and encrypts the partial block.
module aes_block_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BLOCK_BYTES    = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  aes_block_sequencer_if.master bus,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic [2:0] {S_RST, S_FILL, S_START, S_WAIT, S_DRAIN} state_t;

  localparam logic [3:0]  LAST = 4'(BLOCK_BYTES - 1);
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

  state_t       state;
  logic [3:0]   cnt, idx;
  logic [15:0]  timer;
  logic         eop;
  logic [127:0] ct_q;
  logic         take, tx_fire;

  assign take    = bus.rx_valid & bus.rx_ready;
  assign tx_fire = bus.tx_valid & bus.tx_ready;
  assign busy    = (state != S_RST) && ((state != S_FILL) || (cnt != 4'd0));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= S_RST;
      cnt              <= 4'd0;
      idx              <= 4'd0;
      timer            <= 16'd0;
      eop              <= 1'b0;
      ct_q             <= '0;
      err              <= 1'b0;
      bus.rx_ready     <= 1'b0;
      bus.aes_start    <= 1'b0;
      bus.aes_block_in <= '0;
      bus.tx_valid     <= 1'b0;
      bus.tx_data      <= 8'h00;
      bus.tx_eop       <= 1'b0;
    end else begin
      err           <= 1'b0;
      bus.aes_start <= 1'b0;
      case (state)
        S_RST: begin
          state        <= S_FILL;
          bus.rx_ready <= 1'b1;
        end
        S_FILL: if (take) begin
          bus.aes_block_in[{4'd15 - cnt, 3'd0} +: 8] <= bus.rx_data;
          cnt <= cnt + 4'd1;
`ifdef AES_SEQ_PAD_FLUSH_EN
          if (cnt == LAST || bus.rx_eop) begin
            for (int i = 0; i < 16; i++)
              if (4'(i) > cnt) bus.aes_block_in[(15 - i) * 8 +: 8] <= 8'h00;
            eop           <= bus.rx_eop;
            cnt           <= 4'd0;
            timer         <= 16'd0;
            bus.rx_ready  <= 1'b0;
            bus.aes_start <= 1'b1;
            state         <= S_START;
          end
`else
          if (cnt == LAST) begin
            eop           <= bus.rx_eop;
            cnt           <= 4'd0;
            timer         <= 16'd0;
            bus.rx_ready  <= 1'b0;
            bus.aes_start <= 1'b1;
            state         <= S_START;
          end else if (bus.rx_eop) begin
            // short packet: discard what was gathered
            cnt <= 4'd0;
            err <= 1'b1;
          end
`endif
        end
        S_START: begin
          // timer tracks cycles since the start pulse
          timer <= timer + 16'd1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.aes_done) begin
            ct_q         <= bus.aes_block_out;
            idx          <= 4'd0;
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= bus.aes_block_out[127:120];
            bus.tx_eop   <= 1'b0;
            state        <= S_DRAIN;
          end else if (timer == TMAX) begin
            err          <= 1'b1;
            cnt          <= 4'd0;
            eop          <= 1'b0;
            bus.rx_ready <= 1'b1;
            state        <= S_FILL;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_DRAIN: if (tx_fire) begin
          if (idx == LAST) begin
            idx          <= 4'd0;
            cnt          <= 4'd0;
            eop          <= 1'b0;
            bus.tx_valid <= 1'b0;
            bus.tx_eop   <= 1'b0;
            bus.rx_ready <= 1'b1;
            state        <= S_FILL;
          end else begin
            // ct_q shifts so the next byte always sits just below the top
            idx         <= idx + 4'd1;
            ct_q        <= {ct_q[119:0], 8'h00};
            bus.tx_data <= ct_q[119:112];
            bus.tx_eop  <= eop && (idx == LAST - 4'd1);
          end
        end
        default: state <= S_RST;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer with a tiny XOR "AES" model (TIMEOUT_CYCLES=8).
module tb_aes_block_sequencer;
  logic clk = 1'b0;
  logic n_rst;
  logic busy, err;
  int   checks = 0;
  int   fails  = 0;

  aes_block_sequencer_if bus();

  aes_block_sequencer #(.TIMEOUT_CYCLES(8), .BLOCK_BYTES(16)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus.master), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] enc(input logic [127:0] p);
    return p ^ {16{8'h5A}};
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic e);
    bus.rx_valid = 1'b1; bus.rx_data = d; bus.rx_eop = e;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.rx_eop = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] pt, input int n, input logic eop_last);
    for (int i = 0; i < n; i++) send_byte(pt[127 - 8*i -: 8], eop_last && (i == n - 1));
  endtask

  task automatic done_after(input int d, input logic [127:0] ct);
    repeat (d) @(negedge clk);
    bus.aes_done = 1'b1; bus.aes_block_out = ct;
    @(negedge clk);
    bus.aes_done = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat, output logic [127:0] got, output logic [15:0] eops,
                       output int bad_stall, output int cycles);
    int k = 0;
    logic [7:0] held = 8'h00;
    bit stalled = 1'b0;
    got = '0; eops = '0; bad_stall = 0; cycles = 0;
    while (k < 16 && cycles < 200) begin
      bus.tx_ready = pat[cycles % 4];
      if (stalled && bus.tx_data !== held) bad_stall++;
      if (bus.tx_valid && bus.tx_ready) begin
        got[127 - 8*k -: 8] = bus.tx_data;
        eops[k] = bus.tx_eop;
        k++;
        stalled = 1'b0;
      end else if (bus.tx_valid) begin
        stalled = 1'b1;
        held = bus.tx_data;
      end
      cycles++;
      @(negedge clk);
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rx_ready, bus.aes_start, bus.tx_valid, bus.tx_eop, busy, err} !== 6'b0 ||
        bus.aes_block_in !== 128'h0 || bus.tx_data !== 8'h00) begin
      fails++; $display("FAIL reset_outputs: rdy=%b start=%b txv=%b busy=%b err=%b blk=%h want all 0",
        bus.rx_ready, bus.aes_start, bus.tx_valid, busy, err, bus.aes_block_in);
    end
    n_rst = 1'b1;
    checks++;
    if (bus.rx_ready !== 1'b0) begin fails++; $display("FAIL reset_rdy_before_clk: got %b want 0", bus.rx_ready); end
    @(negedge clk);
    checks++;
    if (bus.rx_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_fill: rdy=%b busy=%b want 1 0", bus.rx_ready, busy);
    end
  endtask

  task automatic test_basic;
    logic [127:0] pt = 128'h000102030405060708090A0B0C0D0E0F;
    logic [127:0] got; logic [15:0] eops; int bad, cyc;
    send_bytes(pt, 16, 1'b1);
    checks++;
    if (bus.aes_start !== 1'b1 || bus.aes_block_in !== pt || busy !== 1'b1) begin
      fails++; $display("FAIL basic_start: start=%b blk=%h busy=%b want 1 %h 1", bus.aes_start, bus.aes_block_in, busy, pt);
    end
    @(negedge clk);
    checks++;
    if (bus.aes_start !== 1'b0) begin fails++; $display("FAIL basic_start_once: got %b want 0", bus.aes_start); end
    done_after(3, enc(pt));
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5A) begin
      fails++; $display("FAIL basic_first_tx: txv=%b data=%h want 1 5a", bus.tx_valid, bus.tx_data);
    end
    drain(4'b1111, got, eops, bad, cyc);
    checks++;
    if (got !== enc(pt)) begin fails++; $display("FAIL basic_data: got %h want %h", got, enc(pt)); end
    checks++;
    if (eops !== 16'h8000) begin fails++; $display("FAIL basic_eop: got %h want 8000", eops); end
    checks++;
    if (cyc !== 16) begin fails++; $display("FAIL basic_drain_cycles: got %0d want 16", cyc); end
    checks++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || bus.rx_ready !== 1'b1) begin
      fails++; $display("FAIL basic_idle: txv=%b busy=%b rdy=%b want 0 0 1", bus.tx_valid, busy, bus.rx_ready);
    end
  endtask

  task automatic test_stall;
    logic [127:0] pt = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    logic [127:0] got; logic [15:0] eops; int bad, cyc;
    send_bytes(pt, 16, 1'b0);
    @(negedge clk);
    done_after(2, enc(pt));
    drain(4'b1001, got, eops, bad, cyc);
    checks++;
    if (got !== enc(pt)) begin fails++; $display("FAIL stall_data: got %h want %h", got, enc(pt)); end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL stall_hold: %0d unstable stalled bytes want 0", bad); end
    checks++;
    if (eops !== 16'h0000) begin fails++; $display("FAIL stall_no_eop: got %h want 0000", eops); end
  endtask

  task automatic test_timeout;
    logic [127:0] pt = 128'h11223344556677889900AABBCCDDEEFF;
    logic [127:0] got; logic [15:0] eops; int bad, cyc;
    int n = 0;
    send_bytes(pt, 16, 1'b0);
    while (err !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n !== 8) begin fails++; $display("FAIL timeout_latency: err after %0d cycles want 8", n); end
    checks++;
    if (busy !== 1'b0 || bus.rx_ready !== 1'b1) begin
      fails++; $display("FAIL timeout_fill: busy=%b rdy=%b want 0 1", busy, bus.rx_ready);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL timeout_err_once: got %b want 0", err); end
    send_bytes(pt, 16, 1'b1);
    @(negedge clk);
    done_after(2, enc(pt));
    drain(4'b1111, got, eops, bad, cyc);
    checks++;
    if (got !== enc(pt) || eops !== 16'h8000) begin
      fails++; $display("FAIL timeout_recover: got %h eop %h want %h 8000", got, eops, enc(pt));
    end
  endtask

  task automatic test_done_at_timeout;
    logic [127:0] pt = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    logic [127:0] got; logic [15:0] eops; int bad, cyc;
    send_bytes(pt, 16, 1'b0);
    @(negedge clk);
    done_after(6, enc(pt));
    checks++;
    if (bus.tx_valid !== 1'b1 || err !== 1'b0) begin
      fails++; $display("FAIL done_vs_timeout: txv=%b err=%b want 1 0", bus.tx_valid, err);
    end
    drain(4'b1111, got, eops, bad, cyc);
    checks++;
    if (got !== enc(pt)) begin fails++; $display("FAIL done_vs_timeout_data: got %h want %h", got, enc(pt)); end
  endtask

  task automatic test_eop_mid;
    logic [127:0] pt = 128'h1011121314AA00000000000000000000;
`ifdef AES_SEQ_PAD_FLUSH_EN
    logic [127:0] got; logic [15:0] eops; int bad, cyc;
    send_bytes(pt, 6, 1'b1);
    checks++;
    if (bus.aes_start !== 1'b1 || bus.aes_block_in !== pt) begin
      fails++; $display("FAIL pad_start: start=%b blk=%h want 1 %h", bus.aes_start, bus.aes_block_in, pt);
    end
    @(negedge clk);
    done_after(3, enc(pt));
    drain(4'b1111, got, eops, bad, cyc);
    checks++;
    if (got !== enc(pt) || eops !== 16'h8000) begin
      fails++; $display("FAIL pad_drain: got %h eop %h want %h 8000", got, eops, enc(pt));
    end
`else
    logic [127:0] full = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    send_bytes(pt, 6, 1'b1);
    checks++;
    if (err !== 1'b1 || bus.aes_start !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL drop_err: err=%b start=%b busy=%b want 1 0 0", err, bus.aes_start, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || bus.aes_start !== 1'b0 || bus.rx_ready !== 1'b1) begin
      fails++; $display("FAIL drop_once: err=%b start=%b rdy=%b want 0 0 1", err, bus.aes_start, bus.rx_ready);
    end
    send_bytes(full, 16, 1'b0);
    checks++;
    if (bus.aes_start !== 1'b1 || bus.aes_block_in !== full) begin
      fails++; $display("FAIL drop_cnt_cleared: start=%b blk=%h want 1 %h", bus.aes_start, bus.aes_block_in, full);
    end
    @(negedge clk);
    done_after(1, enc(full));
    begin
      logic [127:0] got; logic [15:0] eops; int bad, cyc;
      drain(4'b1111, got, eops, bad, cyc);
      checks++;
      if (got !== enc(full)) begin fails++; $display("FAIL drop_next_block: got %h want %h", got, enc(full)); end
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic [127:0] pt = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
    send_bytes(pt, 16, 1'b0);
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({bus.rx_ready, bus.aes_start, bus.tx_valid, bus.tx_eop, busy, err} !== 6'b0 ||
        bus.aes_block_in !== 128'h0 || bus.tx_data !== 8'h00) begin
      fails++; $display("FAIL reset_mid_async: rdy=%b busy=%b err=%b blk=%h want all 0",
        bus.rx_ready, busy, err, bus.aes_block_in);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rx_ready !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid_recover: rdy=%b err=%b busy=%b want 1 0 0", bus.rx_ready, err, busy);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_eop = 1'b0;
    bus.aes_done = 1'b0; bus.aes_block_out = '0; bus.tx_ready = 1'b0;
    test_reset;
    test_basic;
    test_stall;
    test_timeout;
    test_done_at_timeout;
    test_eop_mid;
    test_reset_mid;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
